// File: rtl/if_stage_unit.sv
// if_stage_unit: MIPS instruction-fetch stage with PC, imem handshake, one-word hold buffer and IF/ID register.
module if_stage_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_Flush,
    input  logic        PCSrc,
    input  logic        InstSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic [31:0] PC
);
    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, hold_q, hold_d, inst_q, inst_d, pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        advance, redirect;
    logic [31:0] target, pc_plus4;

    assign advance   = PCWrite & IF_ID_Write;
    assign redirect  = PCWrite & (PCSrc | InstSrc);
    assign target    = InstSrc ? {pc4_q[31:28], JumpIndex, 2'b00} : BranchTarget;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_req  = state_q == S_REQ;
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign IF_ID_Inst  = inst_q;
    assign IF_ID_PC4   = pc4_q;
    assign IF_ID_Valid = valid_q;
    assign PC          = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect) begin
            pc_d    = {target[31:2], 2'b00};
            state_d = S_REQ;
            inst_d  = IF_ID_Write ? NOP_INST : inst_q;
            pc4_d   = IF_ID_Write ? pc_plus4 : pc4_q;
            valid_d = IF_ID_Write ? 1'b0 : valid_q;
        end else if (state_q == S_REQ) begin
            if (imem_ack && advance) begin
                inst_d  = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end else if (imem_ack) begin
                hold_d  = imem_rdata;
                state_d = S_HOLD;
            end else if (advance) begin
                inst_d  = NOP_INST;
                pc4_d   = pc_plus4;
                valid_d = 1'b0;
            end
        end else if (advance) begin
            inst_d  = hold_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_REQ;
        end
        // A flush kills the ID slot regardless of IF_ID_Write; PC4 is left as-is.
        if (IF_Flush) begin
            inst_d  = NOP_INST;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= 32'd0;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_if_stage_unit.sv
// tb_if_stage_unit: table-driven cycle vectors with an expected-result queue, plus an async-reset sequence.
module tb_if_stage_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b0, IF_ID_Write = 1'b0, IF_Flush = 1'b0, PCSrc = 1'b0, InstSrc = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic [25:0] JumpIndex = 26'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr, IF_ID_Inst, IF_ID_PC4, PC;
    logic        IF_ID_Valid;

    int checks = 0;
    int errors = 0;

    if_stage_unit dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
        .PCSrc(PCSrc), .InstSrc(InstSrc), .BranchTarget(BranchTarget), .JumpIndex(JumpIndex),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_ID_Inst(IF_ID_Inst), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid), .PC(PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcw, ifw, fl, ps, is;
        logic [31:0] bt;
        logic [25:0] ji;
        logic        ack;
        logic [31:0] rd;
        logic        req;
        logic [31:0] inst, pc4;
        logic        vld, cpc4;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic pcw, logic ifw, logic fl, logic ps, logic is, logic [31:0] bt,
                                logic [25:0] ji, logic ack, logic [31:0] rd, logic req,
                                logic [31:0] inst, logic [31:0] pc4, logic vld, logic cpc4, logic [31:0] pc);
        vec_t v;
        v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.ps = ps; v.is = is; v.bt = bt; v.ji = ji;
        v.ack = ack; v.rd = rd; v.req = req; v.inst = inst; v.pc4 = pc4; v.vld = vld;
        v.cpc4 = cpc4; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // pcw ifw fl ps is bt ji ack rdata | req inst pc4 vld cpc4 pc
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hA0, 1,32'hA0,32'h4,1,1,32'h4));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hA1, 1,32'hA1,32'h8,1,1,32'h8));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hA2, 1,32'hA2,32'hC,1,1,32'hC));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hA3, 1,32'hA3,32'h10,1,1,32'h10));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,32'hBAD, 1,32'h0,32'h0,0,0,32'h10));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,32'hBAD, 1,32'h0,32'h0,0,0,32'h10));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,32'hBAD, 1,32'h0,32'h0,0,0,32'h10));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hB0, 1,32'hB0,32'h14,1,1,32'h14));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'hC0, 0,32'hB0,32'h14,1,1,32'h14));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,32'hBAD, 0,32'hB0,32'h14,1,1,32'h14));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,32'hBAD, 1,32'hC0,32'h18,1,1,32'h18));
        vecs.push_back(mk(1,1,1,1,0,32'h200,0,1,32'hD0, 1,32'h0,32'h18,0,1,32'h200));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'hE0, 0,32'h0,32'h18,0,1,32'h200));
        vecs.push_back(mk(1,0,1,1,0,32'h300,0,1,32'hE1, 1,32'h0,32'h18,0,1,32'h300));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'hF0, 1,32'hF0,32'h304,1,1,32'h304));
        vecs.push_back(mk(1,1,1,1,0,32'h4000_000C,0,0,32'h0, 1,32'h0,32'h304,0,1,32'h4000_000C));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'h11, 1,32'h11,32'h4000_0010,1,1,32'h4000_0010));
        vecs.push_back(mk(0,0,0,1,1,32'h999,26'h40,0,32'h0, 1,32'h11,32'h4000_0010,1,1,32'h4000_0010));
        vecs.push_back(mk(1,1,1,1,1,32'h999,26'h40,0,32'h0, 1,32'h0,32'h4000_0010,0,1,32'h4000_0100));
        vecs.push_back(mk(1,1,1,1,0,32'hFFFF_FFFC,0,0,32'h0, 1,32'h0,32'h4000_0010,0,1,32'hFFFF_FFFC));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'h22, 1,32'h22,32'h0,1,1,32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h33, 0,32'h22,32'h0,1,1,32'h0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0,32'h0, 1,32'h0,32'h0,0,1,32'h4));
        vecs.push_back(mk(1,1,0,1,0,32'h40,0,1,32'h44, 1,32'h0,32'h0,0,0,32'h40));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'h55, 1,32'h55,32'h44,1,1,32'h44));
        vecs.push_back(mk(1,1,1,1,0,32'h7C,0,0,32'h0, 1,32'h0,32'h44,0,1,32'h7C));
        vecs.push_back(mk(1,1,0,0,0,0,0,1,32'h77, 1,32'h77,32'h80,1,1,32'h80));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,32'h0, 1,32'h77,32'h80,1,1,32'h80));

        #1 rst = 1'b0;
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_inst", IF_ID_Inst, 32'h0);
        chk("reset_pc4", IF_ID_PC4, 32'h0);
        chk("reset_valid", {31'd0, IF_ID_Valid}, 32'd0);
        chk("reset_req", {31'd0, imem_req}, 32'd1);
        chk("reset_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = 1'b1;
            PCWrite = vecs[i].pcw; IF_ID_Write = vecs[i].ifw; IF_Flush = vecs[i].fl;
            PCSrc = vecs[i].ps; InstSrc = vecs[i].is; BranchTarget = vecs[i].bt;
            JumpIndex = vecs[i].ji; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rd;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            begin
                vec_t e;
                e = exp_q.pop_front();
                chk($sformatf("v%0d_pc", i), PC, e.pc);
                chk($sformatf("v%0d_addr", i), imem_addr, e.pc);
                chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, e.req});
                chk($sformatf("v%0d_valid", i), {31'd0, IF_ID_Valid}, {31'd0, e.vld});
                chk($sformatf("v%0d_inst", i), IF_ID_Inst, e.inst);
                if (e.cpc4) chk($sformatf("v%0d_pc4", i), IF_ID_PC4, e.pc4);
            end
        end

        #3 rst = 1'b0;
        #1;
        chk("async_rst_pc", PC, 32'h0);
        chk("async_rst_inst", IF_ID_Inst, 32'h0);
        chk("async_rst_pc4", IF_ID_PC4, 32'h0);
        chk("async_rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
        chk("async_rst_addr", imem_addr, 32'h0);
        PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0; PCSrc = 1'b0; InstSrc = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h66;
        @(posedge clk);
        #1 chk("rst_held_pc", PC, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_inst", IF_ID_Inst, 32'h66);
        chk("post_rst_pc4", IF_ID_PC4, 32'h4);
        chk("post_rst_valid", {31'd0, IF_ID_Valid}, 32'd1);
        chk("post_rst_pc", PC, 32'h4);

        if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
